// File: rtl/aes_inv_top.sv
// aes_inv_top: iterative AES-128 inverse cipher, one round per cycle, no S-box ROM.
// Optional last-round-key cache enabled by defining AES_INV_KEY_CACHE_EN.
// +--------------------------------------------------------------------------+
// | Module   : aes_inv_top                                                   |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
`default_nettype none

module aes_inv_top (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key,
  input  logic [127:0] state,
  output logic [127:0] out,
  output logic         busy,
  output logic         done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_KEXP  = 2'd1;
  localparam logic [1:0] S_INIT  = 2'd2;
  localparam logic [1:0] S_ROUND = 2'd3;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // x^254 == x^-1 in GF(2^8); zero maps to zero naturally.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] r;
    r = x;
    for (int i = 0; i < 6; i++) r = gf_mul(gf_mul(r, r), x);
    return gf_mul(r, r);
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] v;
    logic [7:0] o;
    v = gf_inv(a);
    for (int i = 0; i < 8; i++)
      o[i] = v[i] ^ v[(i+4)%8] ^ v[(i+5)%8] ^ v[(i+6)%8] ^ v[(i+7)%8];
    return o ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    logic [7:0] o;
    for (int i = 0; i < 8; i++)
      o[i] = a[(i+2)%8] ^ a[(i+5)%8] ^ a[(i+7)%8];
    return gf_inv(o ^ 8'h05);
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {gf_mul(8'h0e, a0) ^ gf_mul(8'h0b, a1) ^ gf_mul(8'h0d, a2) ^ gf_mul(8'h09, a3),
            gf_mul(8'h09, a0) ^ gf_mul(8'h0e, a1) ^ gf_mul(8'h0b, a2) ^ gf_mul(8'h0d, a3),
            gf_mul(8'h0d, a0) ^ gf_mul(8'h09, a1) ^ gf_mul(8'h0e, a2) ^ gf_mul(8'h0b, a3),
            gf_mul(8'h0b, a0) ^ gf_mul(8'h0d, a1) ^ gf_mul(8'h09, a2) ^ gf_mul(8'h0e, a3)};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  logic [1:0]   fsm_q, fsm_d;
  logic [127:0] data_q, data_d;
  logic [127:0] rk_q, rk_d;
  logic [3:0]   round_q, round_d;
  logic [127:0] out_q, out_d;
  logic         done_q, done_d;
`ifdef AES_INV_KEY_CACHE_EN
  logic [127:0] key_q, key_d;
  logic [127:0] cache_key_q, cache_key_d;
  logic [127:0] cache_rk_q, cache_rk_d;
  logic         cache_valid_q, cache_valid_d;
`endif

  // One SubWord instance serves both directions of the key schedule: forward
  // uses w3 of the current key, inverse uses w3 of the previous key (w3^w2).
  logic [31:0]  sw_in, sw_out, rc_word;
  logic [127:0] rk_fwd, rk_inv;
  logic [127:0] shifted, subbed, added, mixed, round_res;

  always_comb begin
    sw_in   = (fsm_q == S_ROUND) ? (rk_q[31:0] ^ rk_q[63:32]) : rk_q[31:0];
    sw_out  = {sbox(sw_in[23:16]), sbox(sw_in[15:8]), sbox(sw_in[7:0]), sbox(sw_in[31:24])};
    rc_word = {rcon(round_q + 4'd1), 24'h000000};

    rk_fwd[127:96] = rk_q[127:96] ^ sw_out ^ rc_word;
    rk_fwd[95:64]  = rk_q[95:64] ^ rk_fwd[127:96];
    rk_fwd[63:32]  = rk_q[63:32] ^ rk_fwd[95:64];
    rk_fwd[31:0]   = rk_q[31:0]  ^ rk_fwd[63:32];

    rk_inv[31:0]   = rk_q[31:0]  ^ rk_q[63:32];
    rk_inv[63:32]  = rk_q[63:32] ^ rk_q[95:64];
    rk_inv[95:64]  = rk_q[95:64] ^ rk_q[127:96];
    rk_inv[127:96] = rk_q[127:96] ^ sw_out ^ rc_word;
  end

  // Byte i sits at row i%4, column i/4; InvShiftRows rotates row r right by r.
  always_comb begin
    shifted = '0;
    subbed  = '0;
    mixed   = '0;
    for (int i = 0; i < 16; i++) begin
      shifted[127-8*i -: 8] = data_q[127-8*((i%4) + 4*(((i/4) - (i%4) + 4) % 4)) -: 8];
      subbed[127-8*i -: 8]  = inv_sbox(shifted[127-8*i -: 8]);
    end
    added = subbed ^ rk_inv;
    for (int c = 0; c < 4; c++)
      mixed[127-32*c -: 32] = inv_mix_col(added[127-32*c -: 32]);
    round_res = (round_q == 4'd0) ? added : mixed;
  end

  always_comb begin
    fsm_d   = fsm_q;
    data_d  = data_q;
    rk_d    = rk_q;
    round_d = round_q;
    out_d   = out_q;
    done_d  = 1'b0;
`ifdef AES_INV_KEY_CACHE_EN
    key_d         = key_q;
    cache_key_d   = cache_key_q;
    cache_rk_d    = cache_rk_q;
    cache_valid_d = cache_valid_q;
`endif
    case (fsm_q)
      S_IDLE: begin
        if (start) begin
          data_d  = state;
          round_d = 4'd0;
`ifdef AES_INV_KEY_CACHE_EN
          key_d = key;
          if (cache_valid_q && (key == cache_key_q)) begin
            rk_d  = cache_rk_q;
            fsm_d = S_INIT;
          end else begin
            rk_d  = key;
            fsm_d = S_KEXP;
          end
`else
          rk_d  = key;
          fsm_d = S_KEXP;
`endif
        end
      end
      S_KEXP: begin
        rk_d    = rk_fwd;
        round_d = round_q + 4'd1;
        if (round_q == 4'd9) begin
          fsm_d = S_INIT;
`ifdef AES_INV_KEY_CACHE_EN
          cache_key_d   = key_q;
          cache_rk_d    = rk_fwd;
          cache_valid_d = 1'b1;
`endif
        end
      end
      S_INIT: begin
        data_d  = data_q ^ rk_q;
        round_d = 4'd9;
        fsm_d   = S_ROUND;
      end
      default: begin
        rk_d   = rk_inv;
        data_d = round_res;
        if (round_q == 4'd0) begin
          out_d  = round_res;
          done_d = 1'b1;
          fsm_d  = S_IDLE;
        end else begin
          round_d = round_q - 4'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q   <= S_IDLE;
      data_q  <= '0;
      rk_q    <= '0;
      round_q <= 4'd0;
      out_q   <= '0;
      done_q  <= 1'b0;
`ifdef AES_INV_KEY_CACHE_EN
      key_q         <= '0;
      cache_key_q   <= '0;
      cache_rk_q    <= '0;
      cache_valid_q <= 1'b0;
`endif
    end else begin
      fsm_q   <= fsm_d;
      data_q  <= data_d;
      rk_q    <= rk_d;
      round_q <= round_d;
      out_q   <= out_d;
      done_q  <= done_d;
`ifdef AES_INV_KEY_CACHE_EN
      key_q         <= key_d;
      cache_key_q   <= cache_key_d;
      cache_rk_q    <= cache_rk_d;
      cache_valid_q <= cache_valid_d;
`endif
    end
  end

  assign out  = out_q;
  assign done = done_q;
  assign busy = (fsm_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_aes_inv_top.sv
// tb_aes_inv_top: directed bench for aes_inv_top using FIPS-197 vectors and a
// behavioural forward-cipher model for the loopback case.
`default_nettype none

module tb_aes_inv_top;

  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] K3 = 128'h00001111ffff00002222ffff3333ffff;
  localparam logic [127:0] P3 = 128'h00001111222233334444555566667777;
`ifdef AES_INV_KEY_CACHE_EN
  localparam int HIT_LAT = 11;
`else
  localparam int HIT_LAT = 21;
`endif

  logic         clk = 1'b0;
  logic         rst, start, busy, done;
  logic [127:0] key, ct, out;
  int           checks = 0;
  int           errors = 0;

  always #5 clk = ~clk;

  aes_inv_top dut (
    .clk(clk), .rst(rst), .start(start), .key(key), .state(ct),
    .out(out), .busy(busy), .done(done)
  );

  function automatic logic [7:0] m_xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = m_xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] m_rotl(input logic [7:0] b, input int n);
    logic [15:0] t;
    t = {b, b} << n;
    return t[15:8];
  endfunction

  // Inverse found by search, affine written as the rotation form.
  function automatic logic [7:0] m_sbox(input logic [7:0] x);
    logic [7:0] inv = 8'h00;
    logic [7:0] y;
    for (int j = 1; j < 256; j++) begin
      y = j[7:0];
      if (m_mul(x, y) == 8'h01) inv = y;
    end
    return inv ^ m_rotl(inv, 1) ^ m_rotl(inv, 2) ^ m_rotl(inv, 3) ^ m_rotl(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] m_enc(input logic [127:0] k, input logic [127:0] p);
    logic [127:0] s, rk, t;
    logic [31:0]  w3, tmp;
    logic [7:0]   rc, a0, a1, a2, a3;
    s  = p ^ k;
    rk = k;
    rc = 8'h01;
    for (int r = 1; r <= 10; r++) begin
      w3  = rk[31:0];
      tmp = {m_sbox(w3[23:16]), m_sbox(w3[15:8]), m_sbox(w3[7:0]), m_sbox(w3[31:24])} ^ {rc, 24'h0};
      rk[127:96] = rk[127:96] ^ tmp;
      rk[95:64]  = rk[95:64] ^ rk[127:96];
      rk[63:32]  = rk[63:32] ^ rk[95:64];
      rk[31:0]   = rk[31:0] ^ rk[63:32];
      rc = m_xt(rc);
      for (int i = 0; i < 16; i++)
        t[127-8*i -: 8] = m_sbox(s[127-8*((i%4) + 4*(((i/4) + (i%4)) % 4)) -: 8]);
      if (r < 10) begin
        for (int c = 0; c < 4; c++) begin
          {a0, a1, a2, a3} = t[127-32*c -: 32];
          t[127-32*c -: 32] = {m_mul(8'h02, a0) ^ m_mul(8'h03, a1) ^ a2 ^ a3,
                               a0 ^ m_mul(8'h02, a1) ^ m_mul(8'h03, a2) ^ a3,
                               a0 ^ a1 ^ m_mul(8'h02, a2) ^ m_mul(8'h03, a3),
                               m_mul(8'h03, a0) ^ a1 ^ a2 ^ m_mul(8'h02, a3)};
        end
      end
      s = t ^ rk;
    end
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic launch(input logic [127:0] k, input logic [127:0] s);
    key   = k;
    ct    = s;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < 40) begin
      tick();
      cyc++;
    end
  endtask

  initial begin
    int cyc;
    int ndone;
    int lat;
    logic [127:0] got;
    logic [127:0] c3;

    // Reset for two cycles with start asserted; start must not be taken.
    rst = 1'b1; start = 1'b1; key = K1; ct = C1;
    tick();
    check("rst_c1", {out, busy, done}, {128'h0, 1'b0, 1'b0});
    tick();
    check("rst_c2", {out, busy, done}, {128'h0, 1'b0, 1'b0});
    rst = 1'b0; start = 1'b0;
    tick();
    check("rst_release", {out, busy, done}, {128'h0, 1'b0, 1'b0});

    // FIPS-197 appendix C.1 vector.
    launch(K1, C1);
    check("v1_busy_after_start", busy, 1'b1);
    wait_done(cyc);
    check("v1_latency", cyc, 21);
    check("v1_out", out, P1);
    check("v1_busy_at_done", busy, 1'b0);
    tick();
    check("v1_done_one_cycle", done, 1'b0);
    check("v1_out_held", out, P1);

    // Appendix B vector; extra start and key change at E0+5 must be ignored.
    launch(K2, C2);
    ndone = 0; lat = 0; got = '0;
    for (int k = 1; k <= 30; k++) begin
      start = (k == 5);
      if (k == 5) begin key = K3; ct = P3; end
      tick();
      if (done === 1'b1) begin
        ndone++;
        lat = k;
        got = out;
      end
    end
    start = 1'b0;
    check("v2_done_count", ndone, 1);
    check("v2_latency", lat, 21);
    check("v2_out", got, P2);

    // Reset at E0+15 aborts without a done pulse.
    launch(K1, C1);
    ndone = 0;
    for (int k = 1; k <= 14; k++) begin
      tick();
      if (done === 1'b1) ndone++;
    end
    rst = 1'b1;
    tick();
    check("abort_state", {out, busy, done}, {128'h0, 1'b0, 1'b0});
    rst = 1'b0;
    for (int k = 0; k < 25; k++) begin
      tick();
      if (done === 1'b1) ndone++;
    end
    check("abort_no_done", ndone, 0);
    check("abort_out_zero", out, 128'h0);
    launch(K1, C1);
    wait_done(cyc);
    check("rerun_latency", cyc, 21);
    check("rerun_out", out, P1);

    // Back-to-back with start held through done; second run may hit the key cache.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    key = K1; ct = C1; start = 1'b1;
    tick();
    wait_done(cyc);
    check("b2b_first_latency", cyc, 21);
    check("b2b_first_out", out, P1);
    tick();
    start = 1'b0;
    check("b2b_second_accepted", busy, 1'b1);
    wait_done(cyc);
    check("b2b_second_latency", cyc, HIT_LAT);
    check("b2b_second_out", out, P1);
    tick();
    launch(K2, C2);
    wait_done(cyc);
    check("newkey_latency", cyc, 21);
    check("newkey_out", out, P2);
    tick();

    // Loopback against the forward-cipher model.
    c3 = m_enc(K3, P3);
    launch(K3, c3);
    wait_done(cyc);
    check("loop_latency", cyc, 21);
    check("loop_out", out, P3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
